mem_access_ctrl: RTL and testbench

Initiator side of the data-memory interface. Takes MEM-stage load/store requests from the pipeline (Address, WriteData, MemRead, MemWrite), sequences the multi-cycle SRAM read/write strobes on RAM1 or RAM2, returns ReadData, and stalls the pipeline until the access completes. It sits between the MEM stage and the external SRAM pins, and consumes the AddressSrc routing decision produced by the data-memory model.

---
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: turns MEM-stage load/store requests into multi-cycle
// SRAM strobe sequences on RAM1 or RAM2 and holds the pipeline until done.
module mem_access_ctrl #(
    parameter int RD_WAIT_CYCLES  = 2,
    parameter int WR_PULSE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        AddressSrc,
    input  logic [15:0] ram_din,
    output logic [15:0] ReadData,
    output logic        Stall,
    output logic [17:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic        ram_dout_en,
    output logic        ram1_en_n,
    output logic        ram2_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam int CMAX = (RD_WAIT_CYCLES > WR_PULSE_CYCLES) ? RD_WAIT_CYCLES : WR_PULSE_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [15:0]   addr_reg, addr_next;
    logic [15:0]   wdata_reg, wdata_next;
    logic          sel_reg, sel_next;
    logic [15:0]   rdata_reg, rdata_next;

    // Strobes are registered from the next-state decode so the SRAM pins
    // never glitch while still lining up exactly with the state they belong to.
    logic [1:0]    en_n_reg, en_n_next;
    logic          oe_n_reg, oe_n_next;
    logic          we_n_reg, we_n_next;
    logic          dout_en_reg, dout_en_next;
    logic          busy_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            sel_reg     <= 1'b0;
            rdata_reg   <= '0;
            en_n_reg    <= 2'b11;
            oe_n_reg    <= 1'b1;
            we_n_reg    <= 1'b1;
            dout_en_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            sel_reg     <= sel_next;
            rdata_reg   <= rdata_next;
            en_n_reg    <= en_n_next;
            oe_n_reg    <= oe_n_next;
            we_n_reg    <= we_n_next;
            dout_en_reg <= dout_en_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        sel_next   = sel_reg;
        rdata_next = rdata_reg;
        unique case (state_reg)
            IDLE: begin
                // Loads win over stores when both are requested.
                if (MemRead) begin
                    addr_next  = Address;
                    sel_next   = AddressSrc;
                    cnt_next   = RD_LOAD;
                    state_next = RD_WAIT;
                end else if (MemWrite) begin
                    addr_next  = Address;
                    wdata_next = WriteData;
                    sel_next   = AddressSrc;
                    state_next = WR_SETUP;
                end
            end
            RD_WAIT: begin
                if (cnt_reg == '0) begin
                    rdata_next = ram_din;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WR_SETUP: begin
                cnt_next   = WR_LOAD;
                state_next = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_reg == '0) begin
                    state_next = WR_HOLD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WR_HOLD: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next    = (state_next == RD_WAIT) || (state_next == WR_SETUP) ||
                       (state_next == WR_PULSE) || (state_next == WR_HOLD);
        oe_n_next    = (state_next != RD_WAIT);
        we_n_next    = (state_next != WR_PULSE);
        dout_en_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                       (state_next == WR_HOLD);
    end

    // One chip enable per bank; only the latched bank can ever go low.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_en
            assign en_n_next[gi] = !(busy_next && (sel_next == 1'(gi)));
        end
    endgenerate

    assign Stall       = (MemRead || MemWrite) && (state_reg != DONE);
    assign ReadData    = rdata_reg;
    assign ram_addr    = {2'b00, addr_reg};
    assign ram_dout    = wdata_reg;
    assign ram_dout_en = dout_en_reg;
    assign ram1_en_n   = en_n_reg[0];
    assign ram2_en_n   = en_n_reg[1];
    assign ram_oe_n    = oe_n_reg;
    assign ram_we_n    = we_n_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a two-bank behavioural SRAM;
// every cycle of each access is compared against a hand-written strobe table.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Address, WriteData, ram_din, ReadData, ram_dout;
    logic        MemRead, MemWrite, AddressSrc;
    logic        Stall, ram_dout_en, ram1_en_n, ram2_en_n, ram_oe_n, ram_we_n;
    logic [17:0] ram_addr;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    // {Stall, ram1_en_n, ram2_en_n, ram_oe_n, ram_we_n, ram_dout_en}
    localparam logic [5:0] S_IDLE_REQ = 6'b111110;
    localparam logic [5:0] S_QUIET    = 6'b011110;
    localparam logic [5:0] S_RD1      = 6'b110010;
    localparam logic [5:0] S_RD0      = 6'b101010;
    localparam logic [5:0] S_WSET0    = 6'b101111;
    localparam logic [5:0] S_WPUL0    = 6'b101101;
    localparam logic [5:0] S_WSET1    = 6'b110111;
    localparam logic [5:0] S_WPUL1    = 6'b110101;

    mem_access_ctrl #(.RD_WAIT_CYCLES(2), .WR_PULSE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .AddressSrc(AddressSrc),
        .ram_din(ram_din), .ReadData(ReadData), .Stall(Stall),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_en(ram_dout_en),
        .ram1_en_n(ram1_en_n), .ram2_en_n(ram2_en_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_we_n && ram_dout_en) begin
            if (!ram1_en_n) mem1[ram_addr[7:0]] <= ram_dout;
            if (!ram2_en_n) mem2[ram_addr[7:0]] <= ram_dout;
        end
    end

    assign ram_din = (!ram_oe_n && !ram1_en_n) ? mem1[ram_addr[7:0]] :
                     (!ram_oe_n && !ram2_en_n) ? mem2[ram_addr[7:0]] : 16'h0000;

    function automatic logic [5:0] pins();
        return {Stall, ram1_en_n, ram2_en_n, ram_oe_n, ram_we_n, ram_dout_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemRead = 0; MemWrite = 0; AddressSrc = 0;
        Address = 16'h0; WriteData = 16'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (pins() !== S_QUIET) begin
            errors++; $display("FAIL reset_pins got=%b exp=%b", pins(), S_QUIET);
        end
        checks++;
        if (ReadData !== 16'h0 || ram_addr !== 18'h0 || ram_dout !== 16'h0) begin
            errors++; $display("FAIL reset_regs got rd=%h addr=%h dout=%h exp all 0", ReadData, ram_addr, ram_dout);
        end
        $display("reset: pins=%b rd=%h", pins(), ReadData);
    endtask

    task automatic test_read();
        logic [5:0] exp_seq [4] = '{S_IDLE_REQ, S_RD1, S_RD1, S_QUIET};
        Address = 16'h0040; AddressSrc = 1'b1; MemRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (pins() !== exp_seq[i]) begin
                errors++; $display("FAIL read_pins cyc=%0d got=%b exp=%b", i, pins(), exp_seq[i]);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (ram_addr !== 18'h00040) begin
                    errors++; $display("FAIL read_addr cyc=%0d got=%h exp=00040", i, ram_addr);
                end
            end
            if (i == 3) begin
                checks++;
                if (ReadData !== 16'hBEEF) begin
                    errors++; $display("FAIL read_data got=%h exp=beef", ReadData);
                end
                MemRead = 1'b0;
            end
            tick();
        end
        $display("read 0040/ram2: ReadData=%h", ReadData);
    endtask

    task automatic test_write();
        logic [5:0] exp_seq [5] = '{S_IDLE_REQ, S_WSET0, S_WPUL0, S_WSET0, S_QUIET};
        Address = 16'h0010; WriteData = 16'h1234; AddressSrc = 1'b0; MemWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // Post-accept input changes must not reach the SRAM pins.
            if (i == 1) begin Address = 16'h00FF; WriteData = 16'hFFFF; AddressSrc = 1'b1; end
            #1;
            checks++;
            if (pins() !== exp_seq[i]) begin
                errors++; $display("FAIL write_pins cyc=%0d got=%b exp=%b", i, pins(), exp_seq[i]);
            end
            if (i >= 1 && i <= 3) begin
                checks++;
                if (ram_dout !== 16'h1234 || ram_addr !== 18'h00010) begin
                    errors++; $display("FAIL write_bus cyc=%0d got dout=%h addr=%h exp 1234/00010", i, ram_dout, ram_addr);
                end
            end
            if (i == 4) begin
                checks++;
                if (ReadData !== 16'hBEEF) begin
                    errors++; $display("FAIL write_keeps_rd got=%h exp=beef", ReadData);
                end
                MemWrite = 1'b0;
            end
            tick();
        end
        checks++;
        if (mem1[8'h10] !== 16'h1234) begin
            errors++; $display("FAIL write_mem got=%h exp=1234", mem1[8'h10]);
        end
        $display("write 0010/ram1: mem=%h", mem1[8'h10]);
    endtask

    task automatic test_read_priority();
        logic [5:0] exp_seq [4] = '{S_IDLE_REQ, S_RD0, S_RD0, S_QUIET};
        Address = 16'h0010; WriteData = 16'hDEAD; AddressSrc = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (pins() !== exp_seq[i]) begin
                errors++; $display("FAIL prio_pins cyc=%0d got=%b exp=%b", i, pins(), exp_seq[i]);
            end
            if (i == 3) begin
                checks++;
                if (ReadData !== 16'h1234) begin
                    errors++; $display("FAIL prio_data got=%h exp=1234", ReadData);
                end
                MemRead = 1'b0; MemWrite = 1'b0;
            end
            tick();
        end
        $display("read+write 0010: ReadData=%h", ReadData);
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_seq [9] = '{S_IDLE_REQ, S_WSET1, S_WPUL1, S_WSET1, S_QUIET,
                                    S_IDLE_REQ, S_RD1, S_RD1, S_QUIET};
        Address = 16'h0020; WriteData = 16'h5A5A; AddressSrc = 1'b1; MemWrite = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (pins() !== exp_seq[i]) begin
                errors++; $display("FAIL b2b_pins cyc=%0d got=%b exp=%b", i, pins(), exp_seq[i]);
            end
            if (i == 4) begin
                MemWrite = 1'b0; MemRead = 1'b1;
            end
            if (i == 8) begin
                checks++;
                if (ReadData !== 16'h5A5A) begin
                    errors++; $display("FAIL b2b_data got=%h exp=5a5a", ReadData);
                end
                MemRead = 1'b0;
            end
            tick();
        end
        $display("write-then-read 0020/ram2: ReadData=%h", ReadData);
    endtask

    task automatic test_flush();
        logic [5:0] exp_seq [4] = '{S_IDLE_REQ, 6'b010010, 6'b010010, S_QUIET};
        Address = 16'h0040; AddressSrc = 1'b1; MemRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) MemRead = 1'b0;
            #1;
            checks++;
            if (pins() !== exp_seq[i]) begin
                errors++; $display("FAIL flush_pins cyc=%0d got=%b exp=%b", i, pins(), exp_seq[i]);
            end
            tick();
        end
        checks++;
        if (ReadData !== 16'hBEEF) begin
            errors++; $display("FAIL flush_data got=%h exp=beef", ReadData);
        end
        $display("flushed read 0040: ReadData=%h", ReadData);
    endtask

    task automatic test_reset_mid_write();
        logic [5:0] exp_seq [4] = '{S_IDLE_REQ, S_RD1, S_RD1, S_QUIET};
        Address = 16'h0030; WriteData = 16'h7777; AddressSrc = 1'b0; MemWrite = 1'b1;
        tick(); tick();
        checks++;
        if (pins() !== S_WPUL0) begin
            errors++; $display("FAIL rstw_pulse got=%b exp=%b", pins(), S_WPUL0);
        end
        rst = 1'b1; MemWrite = 1'b0;
        tick();
        checks++;
        if (pins() !== S_QUIET || ReadData !== 16'h0 || ram_addr !== 18'h0 || ram_dout !== 16'h0) begin
            errors++; $display("FAIL rstw_clear got pins=%b rd=%h addr=%h dout=%h exp %b/0/0/0",
                               pins(), ReadData, ram_addr, ram_dout, S_QUIET);
        end
        rst = 1'b0;
        tick();
        Address = 16'h0040; AddressSrc = 1'b1; MemRead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (pins() !== exp_seq[i]) begin
                errors++; $display("FAIL rstw_read cyc=%0d got=%b exp=%b", i, pins(), exp_seq[i]);
            end
            if (i == 3) MemRead = 1'b0;
            tick();
        end
        checks++;
        if (ReadData !== 16'hBEEF) begin
            errors++; $display("FAIL rstw_data got=%h exp=beef", ReadData);
        end
        $display("reset in WR_PULSE then read: ReadData=%h", ReadData);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0;
            mem2[i] = 16'h0;
        end
        mem2[8'h40] = 16'hBEEF;
        test_reset();
        test_read();
        test_write();
        test_read_priority();
        test_back_to_back();
        test_flush();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout after 100000 time units");
        $fatal(1);
    end

endmodule
